flght_cntrl_seq: RTL and testbench
==================================

# flght_cntrl_seq

Parametrised, sequential successor to the quadcopter flight controller. On each accepted inertial `vld` it computes saturated pitch/roll/yaw errors, P terms and queue-based D terms one axis per cycle through a small FSM, then mixes them with thrust into four clipped 11-bit motor speeds. It sits between the inertial interface / command config and the ESC interface. The D-term queue depth, error width, gains and speed constants are parameters.

## Interface
- `ERR_W`, 10, saturated error width in bits, signed; legal range 8..14.
- `D_QUEUE_DEPTH`, 12, number of past errors kept per axis; the D term compares against the oldest one.
- `D_COEFF`, 7, unsigned D gain.
- `MIN_RUN_SPEED`, 416, idle offset added to every motor.
- `CAL_SPEED`, 688, speed driven on all motors while `inertial_cal` is high.

- `clk` in 1 system clock
- `rst` in 1 synchronous, active-high reset
- `vld` in 1 new inertial reading; 1-cycle pulse
- `inertial_cal` in 1 forces calibration speed on all motors
- `d_ptch`, `d_roll`, `d_yaw` in 16 each, signed desired angles
- `ptch`, `roll`, `yaw` in 16 each, signed actual angles
- `thrst` in 9, unsigned thrust
- `frnt_spd`, `bck_spd`, `lft_spd`, `rght_spd` out 11 each, unsigned motor speeds
- `busy` out 1, FSM not IDLE
- `done` out 1, 1-cycle pulse when the speed registers update
- `ovr` out 1, 1-cycle pulse when `vld` is dropped because the block is busy

## Operation
- FSM states: IDLE → PTCH → ROLL → YAW → MIX → IDLE. Each state lasts exactly one cycle.
- IDLE with `vld`=1:
  - latches all nine angle inputs and `thrst`;
  - goes to PTCH.
- Per axis state:
  - err = actual − desired, as a 17-bit signed value.
  - Saturate err to ERR_W signed: [−2^(ERR_W−1), 2^(ERR_W−1)−1].
  - pterm = (err_sat·5) >>> 3, arithmetic shift.
  - diff = err_sat − queue[axis][rd_ptr], saturated to signed 7 bits [−64, 63].
  - dterm = diff · D_COEFF.
  - Write err_sat into queue[axis][wr_ptr].
- Queues:
  - Three circular buffers, each D_QUEUE_DEPTH × ERR_W, all entries cleared to 0 by reset.
  - rd_ptr == wr_ptr is the oldest slot. The write replaces it after the read.
  - A shared pointer advances in YAW and wraps from D_QUEUE_DEPTH−1 to 0.
- MIX, all sums signed 14-bit, where Xt = pterm + dterm for axis X:
  - frnt = MIN_RUN_SPEED + thrst + Pt − Yt
  - bck = MIN_RUN_SPEED + thrst − Pt − Yt
  - lft = MIN_RUN_SPEED + thrst + Rt + Yt
  - rght = MIN_RUN_SPEED + thrst − Rt + Yt
  - Each result is clipped to [0, 2047], registered into its speed register, and `done` pulses.
- Output mux: `*_spd` = `inertial_cal` ? CAL_SPEED : speed register. The mux is combinational, so it has no latency.
- `vld` while `busy`: dropped. `ovr`=1 for that cycle; latched inputs, queues and FSM are unaffected.

## Timing
- `vld` sampled high at edge N: `busy` high from N+1 through N+4. Speed registers and `done` update at edge N+4, i.e. 4-cycle latency. Back in IDLE at N+5.
- Back-to-back: a `vld` at N+4 is dropped (`ovr`). A `vld` at N+5 is accepted, giving maximum throughput of 1 reading per 5 cycles.
- Reset values:
  - speed registers 0, so outputs read 0 unless `inertial_cal`=1;
  - `busy`, `done`, `ovr` 0;
  - FSM IDLE, pointer 0, queues 0.
- `rst` mid-sequence:
  - aborts to IDLE next edge;
  - no `done`;
  - queues and pointer cleared; speed registers 0.
- `rst` and `vld` in the same cycle: reset wins and `vld` is ignored.

## Configuration
- `FLGHT_CNTRL_DTERM_EN` defined: queues, subtractors and D multiply are compiled in, with behaviour as above.
- Not defined:
  - no queue storage is built;
  - dterm is 0 on all axes and the pointer is absent;
  - the FSM, latency and P path are unchanged.

## Test plan
- First sample, D enabled, defaults: desired all 0, ptch=100, roll=yaw=0, thrst=200.
  - pterm=62, diff sat 63, dterm=441.
  - Expect frnt=1119, bck=113, lft=rght=616 at N+4, with `done` pulse.
- Hold the same stimulus for 13 accepted `vld`s.
  - Samples 2–12 still give frnt=1119, since the oldest slot is 0.
  - Sample 13 gives diff=0: frnt=678, bck=554. This checks pointer wrap.
- Saturation/clip: ptch=16'h7FFF, thrst=0, first sample.
  - err_sat=511, pterm=319, dterm=441.
  - Expect frnt=1176, bck=0 (negative clipped), lft=rght=416.
- Drive `vld` on 2 consecutive edges.
  - Second is dropped with `ovr` pulse; only one `done`.
  - Then `vld` at N+5 is accepted.
- `inertial_cal`=1 with any stimulus: all speeds read 688 the same cycle. Deassert: previous registered speeds reappear.
- Assert `rst` at N+2 of a sequence: no `done`, outputs 0, `busy` 0 next cycle. The next sample behaves as a first sample (dterm from empty queue).

Source files
------------

// File: rtl/flght_cntrl_seq_if.sv
// Inertial/command inputs and ESC-side outputs of flght_cntrl_seq.
// master drives readings and observes speeds; slave is the controller.
interface flght_cntrl_seq_if;
    logic               vld;
    logic               inertial_cal;
    logic signed [15:0] d_ptch, d_roll, d_yaw;
    logic signed [15:0] ptch, roll, yaw;
    logic        [8:0]  thrst;
    logic        [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic               busy;
    logic               done;
    logic               ovr;

    modport master (
        output vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        input  frnt_spd, bck_spd, lft_spd, rght_spd, busy, done, ovr
    );

    modport slave (
        input  vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        output frnt_spd, bck_spd, lft_spd, rght_spd, busy, done, ovr
    );
endinterface

// File: rtl/flght_cntrl_seq.sv
// Sequential flight controller: one axis per cycle (PTCH/ROLL/YAW), then MIX into four motor speeds.
// Define FLGHT_CNTRL_DTERM_EN to build the per-axis D-term history queues; otherwise dterm is 0.
module flght_cntrl_seq #(
    parameter int ERR_W         = 10,
    parameter int D_QUEUE_DEPTH = 12,
    parameter int D_COEFF       = 7,
    parameter int MIN_RUN_SPEED = 416,
    parameter int CAL_SPEED     = 688
) (
    input logic               clk,
    input logic               rst,
    flght_cntrl_seq_if.slave  bus
);

    if (ERR_W < 8 || ERR_W > 14 || D_QUEUE_DEPTH < 1 || D_COEFF < 0 || D_COEFF > 127) begin : g_bad_param
        $error("flght_cntrl_seq: parameter out of range");
    end

    localparam logic signed [16:0] ERR_HI = 17'((1 << (ERR_W - 1)) - 1);
    localparam logic signed [16:0] ERR_LO = ~ERR_HI;

    typedef enum logic [2:0] {IDLE, PTCH, ROLL, YAW, MIX} state_t;
    state_t state, state_nxt;

    logic signed [15:0]      d_ptch_q, d_roll_q, d_yaw_q, ptch_q, roll_q, yaw_q;
    logic        [8:0]       thrst_q;
    logic signed [13:0]      pt_q, rt_q, yt_q;
    logic        [10:0]      frnt_q, bck_q, lft_q, rght_q;
    logic                    done_q;

    logic signed [15:0]      act, des;
    logic signed [16:0]      err;
    logic signed [ERR_W-1:0] err_sat;
    logic signed [ERR_W+2:0] err_x5;
    logic signed [ERR_W-1:0] pterm;
    logic signed [13:0]      dterm, xt;
    logic signed [13:0]      base;

    function automatic logic [10:0] clip(input logic signed [13:0] v);
        if (v < 14'sd0)
            return '0;
        else if (v > 14'sd2047)
            return '1;
        else
            return v[10:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = (state != IDLE);
        bus.ovr   = 1'b0;
        case (state)
            IDLE:    if (bus.vld) state_nxt = PTCH;
            PTCH:    state_nxt = ROLL;
            ROLL:    state_nxt = YAW;
            YAW:     state_nxt = MIX;
            MIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.vld && state != IDLE && !rst)
            bus.ovr = 1'b1;
    end

    // Shared axis datapath: the state selects which latched angle pair feeds it.
    always_comb begin
        act = ptch_q;
        des = d_ptch_q;
        case (state)
            ROLL: begin act = roll_q; des = d_roll_q; end
            YAW:  begin act = yaw_q;  des = d_yaw_q;  end
            default: ;
        endcase
        err = 17'(act) - 17'(des);
        if (err > ERR_HI)
            err_sat = ERR_W'(ERR_HI);
        else if (err < ERR_LO)
            err_sat = ERR_W'(ERR_LO);
        else
            err_sat = ERR_W'(err);
        err_x5 = ((ERR_W+3)'(err_sat) <<< 2) + (ERR_W+3)'(err_sat);
        // Dropping the low 3 bits of the signed product is the arithmetic >>> 3.
        pterm  = err_x5[ERR_W+2:3];
        xt     = 14'(pterm) + dterm;
    end

`ifdef FLGHT_CNTRL_DTERM_EN
    localparam int PTR_W = (D_QUEUE_DEPTH > 1) ? $clog2(D_QUEUE_DEPTH) : 1;
    localparam logic signed [ERR_W:0] DIFF_HI = (ERR_W+1)'(63);
    localparam logic signed [ERR_W:0] DIFF_LO = (ERR_W+1)'(-64);

    logic signed [ERR_W-1:0] dq [3][D_QUEUE_DEPTH];
    logic        [PTR_W-1:0] ptr;
    logic        [1:0]       ax;
    logic signed [ERR_W-1:0] oldest;
    logic signed [ERR_W:0]   diff;
    logic signed [6:0]       diff_sat;

    always_comb begin
        ax = (state == ROLL) ? 2'd1 : (state == YAW) ? 2'd2 : 2'd0;
        oldest = dq[ax][ptr];
        diff = (ERR_W+1)'(err_sat) - (ERR_W+1)'(oldest);
        if (diff > DIFF_HI)
            diff_sat = 7'sd63;
        else if (diff < DIFF_LO)
            diff_sat = -7'sd64;
        else
            diff_sat = 7'(diff);
        dterm = 14'(diff_sat) * 14'(D_COEFF);
    end

    // The oldest slot is read combinationally and overwritten at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int unsigned a = 0; a < 3; a++)
                for (int unsigned i = 0; i < D_QUEUE_DEPTH; i++)
                    dq[a][i] <= '0;
        end else begin
            if (state == PTCH || state == ROLL || state == YAW)
                dq[ax][ptr] <= err_sat;
            if (state == YAW)
                ptr <= (ptr == PTR_W'(D_QUEUE_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end
`else
    always_comb dterm = '0;
`endif

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.vld && !rst) begin
            d_ptch_q <= bus.d_ptch;
            d_roll_q <= bus.d_roll;
            d_yaw_q  <= bus.d_yaw;
            ptch_q   <= bus.ptch;
            roll_q   <= bus.roll;
            yaw_q    <= bus.yaw;
            thrst_q  <= bus.thrst;
        end
        case (state)
            PTCH:    pt_q <= xt;
            ROLL:    rt_q <= xt;
            YAW:     yt_q <= xt;
            default: ;
        endcase
    end

    always_comb base = 14'(MIN_RUN_SPEED) + 14'(thrst_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            frnt_q <= '0;
            bck_q  <= '0;
            lft_q  <= '0;
            rght_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == MIX);
            if (state == MIX) begin
                frnt_q <= clip(base + pt_q - yt_q);
                bck_q  <= clip(base - pt_q - yt_q);
                lft_q  <= clip(base + rt_q + yt_q);
                rght_q <= clip(base - rt_q + yt_q);
            end
        end
    end

    always_comb begin
        bus.done     = done_q;
        bus.frnt_spd = bus.inertial_cal ? 11'(CAL_SPEED) : frnt_q;
        bus.bck_spd  = bus.inertial_cal ? 11'(CAL_SPEED) : bck_q;
        bus.lft_spd  = bus.inertial_cal ? 11'(CAL_SPEED) : lft_q;
        bus.rght_spd = bus.inertial_cal ? 11'(CAL_SPEED) : rght_q;
    end

endmodule

// File: tb/tb_flght_cntrl_seq.sv
// Scoreboard bench for flght_cntrl_seq: stimulus pushes expected speeds, a monitor pops on done.
// Expected constants follow the FLGHT_CNTRL_DTERM_EN setting of the build.
module tb_flght_cntrl_seq;

`ifdef FLGHT_CNTRL_DTERM_EN
    localparam int S1_F  = 1119, S1_B  = 113;
    localparam int SAT_F = 1176, SAT_B = 0;
    localparam int MX_F  = 411,  MX_B  = 655, MX_L = 594, MX_R = 1204;
`else
    localparam int S1_F  = 678,  S1_B  = 554;
    localparam int SAT_F = 735,  SAT_B = 97;
    localparam int MX_F  = 691,  MX_B  = 711, MX_L = 706, MX_R = 756;
`endif
    localparam int ST_F = 678, ST_B = 554, ST_LR = 616;

    typedef struct {
        int f;
        int b;
        int l;
        int r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    flght_cntrl_seq_if bus();

    flght_cntrl_seq #(
        .ERR_W(10), .D_QUEUE_DEPTH(12), .D_COEFF(7), .MIN_RUN_SPEED(416), .CAL_SPEED(688)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic push(input int f, input int b, input int l, input int r);
        exp_t e;
        e.f = f; e.b = b; e.l = l; e.r = r;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must correspond to a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", int'(bus.done), 0);
                end else begin
                    e = sb.pop_front();
                    check("frnt_spd", int'(bus.frnt_spd), e.f);
                    check("bck_spd",  int'(bus.bck_spd),  e.b);
                    check("lft_spd",  int'(bus.lft_spd),  e.l);
                    check("rght_spd", int'(bus.rght_spd), e.r);
                end
            end
        end
    end

    task automatic set_in(input int dp, input int dr, input int dy,
                          input int p, input int r, input int y, input int t);
        bus.d_ptch = 16'(dp); bus.d_roll = 16'(dr); bus.d_yaw = 16'(dy);
        bus.ptch   = 16'(p);  bus.roll   = 16'(r);  bus.yaw   = 16'(y);
        bus.thrst  = 9'(t);
    endtask

    task automatic issue(input int dp, input int dr, input int dy,
                         input int p, input int r, input int y, input int t);
        @(negedge clk); #2;
        set_in(dp, dr, dy, p, r, y, t);
        bus.vld = 1'b1;
        #1 check("ovr_idle", int'(bus.ovr), 0);
        @(posedge clk); #1;
        bus.vld = 1'b0;
    endtask

    task automatic sample(input int dp, input int dr, input int dy,
                          input int p, input int r, input int y, input int t,
                          input int ef, input int eb, input int el, input int er);
        push(ef, eb, el, er);
        issue(dp, dr, dy, p, r, y, t);
        @(negedge clk);
        check("busy_run", int'(bus.busy), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("busy_end", int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.vld = 1'b0;
        bus.inertial_cal = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_ovr",  int'(bus.ovr),  0);
        check("rst_frnt", int'(bus.frnt_spd), 0);
        check("rst_rght", int'(bus.rght_spd), 0);

        #2 bus.inertial_cal = 1'b1;
        #1 check("cal_frnt", int'(bus.frnt_spd), 688);
        check("cal_lft", int'(bus.lft_spd), 688);
        bus.inertial_cal = 1'b0;
        #1 check("uncal_bck", int'(bus.bck_spd), 0);

        // 13 identical readings: the 13th sees its own first error as oldest.
        for (int k = 1; k <= 13; k++) begin
            if (k < 13)
                sample(0, 0, 0, 100, 0, 0, 200, S1_F, S1_B, ST_LR, ST_LR);
            else
                sample(0, 0, 0, 100, 0, 0, 200, ST_F, ST_B, ST_LR, ST_LR);
        end

        #2 bus.inertial_cal = 1'b1;
        #1 check("cal_frnt2", int'(bus.frnt_spd), 688);
        check("cal_bck2",  int'(bus.bck_spd),  688);
        check("cal_rght2", int'(bus.rght_spd), 688);
        bus.inertial_cal = 1'b0;
        #1 check("uncal_frnt", int'(bus.frnt_spd), ST_F);
        check("uncal_bck", int'(bus.bck_spd), ST_B);

        // Back-to-back vld: second is dropped, third at N+5 is accepted.
        push(ST_F, ST_B, ST_LR, ST_LR);
        @(negedge clk); #2;
        set_in(0, 0, 0, 100, 0, 0, 200);
        bus.vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_drop", int'(bus.ovr), 1);
        #2 bus.roll = 16'sh7FFF;
        @(posedge clk); #1;
        bus.vld = 1'b0;
        bus.roll = 16'sd0;
        @(negedge clk);
        check("ovr_clear", int'(bus.ovr), 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        push(ST_F, ST_B, ST_LR, ST_LR);
        bus.vld = 1'b1;
        #1 check("ovr_n5", int'(bus.ovr), 0);
        @(posedge clk); #1;
        bus.vld = 1'b0;
        @(negedge clk);
        check("busy_n5", int'(bus.busy), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);

        // Reset at N+2 aborts the sequence and empties the history.
        issue(0, 0, 0, 100, 0, 0, 200);
        @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_frnt", int'(bus.frnt_spd), 0);
        check("abort_lft",  int'(bus.lft_spd),  0);
        repeat (5) @(posedge clk);
        sample(0, 0, 0, 100, 0, 0, 200, S1_F, S1_B, ST_LR, ST_LR);

        // rst and vld together: vld ignored.
        @(negedge clk); #2;
        rst = 1'b1;
        bus.vld = 1'b1;
        #1 check("rst_vld_ovr", int'(bus.ovr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.vld = 1'b0;
        @(negedge clk);
        check("rst_vld_busy", int'(bus.busy), 0);

        sample(0, 0, 0, 32767, 0, 0, 0, SAT_F, SAT_B, 416, 416);

        do_reset();
        sample(16, 0, 6, 0, -40, 30, 300, MX_F, MX_B, MX_L, MX_R);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pending_expect", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
